// File: rtl/smol_alu_arbiter.sv
// Two-port valid/ready front end for the shared combinational smolALU: arbitrates, registers operands, returns the result.
// Optional macro SMOL_ARB_FIXED_PRIO_EN: port 0 always wins ties (default is round-robin).
module smol_alu_arbiter #(
    parameter int PC_W   = 5,
    parameter int OP_W   = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req0_rs1,
    input  logic [DATA_W-1:0] req1_rs1,
    input  logic [DATA_W-1:0] req0_opnd,
    input  logic [DATA_W-1:0] req1_opnd,
    input  logic [PC_W-1:0]   req0_pc,
    input  logic [PC_W-1:0]   req1_pc,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [OP_W-1:0]   req1_op,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_carry,
    output logic              rsp_overflow,
    output logic [DATA_W-1:0] alu_rs1,
    output logic [DATA_W-1:0] alu_rs2_or_imm,
    output logic [PC_W-1:0]   alu_pc,
    output logic [OP_W-1:0]   alu_op_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_carry,
    input  logic              alu_overflow,
    output logic              busy
);

    // Handshake: a request transfers on the rising edge where req_valid[i] & req_ready[i];
    // a response transfers where rsp_valid[i] & rsp_ready[i]. Valid may drop before a transfer.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;
    logic   owner;
    logic   grant;

    always_comb begin
        grant = 1'b0;
        if (req_valid == 2'b11) begin
`ifdef SMOL_ARB_FIXED_PRIO_EN
            grant = 1'b0;
`else
            grant = ~last_grant;
`endif
        end else if (req_valid[1]) begin
            grant = 1'b1;
        end
    end

    always_comb begin
        req_ready = 2'b00;
        if (!rst && state == IDLE && req_valid != 2'b00) begin
            req_ready[grant] = 1'b1;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            owner          <= 1'b0;
            rsp_valid      <= 2'b00;
            rsp_data       <= '0;
            rsp_carry      <= 1'b0;
            rsp_overflow   <= 1'b0;
            alu_rs1        <= '0;
            alu_rs2_or_imm <= '0;
            alu_pc         <= '0;
            alu_op_sel     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Any valid request is granted in IDLE, so valid alone means handshake.
                    if (req_valid != 2'b00) begin
                        alu_rs1        <= grant ? req1_rs1  : req0_rs1;
                        alu_rs2_or_imm <= grant ? req1_opnd : req0_opnd;
                        alu_pc         <= grant ? req1_pc   : req0_pc;
                        alu_op_sel     <= grant ? req1_op   : req0_op;
                        owner          <= grant;
                        last_grant     <= grant;
                        state          <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data         <= alu_out;
                    rsp_carry        <= alu_carry;
                    rsp_overflow     <= alu_overflow;
                    rsp_valid[owner] <= 1'b1;
                    state            <= RESP;
                end
                RESP: begin
                    if (rsp_ready[owner]) begin
                        rsp_valid <= 2'b00;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_smol_alu_arbiter.sv
// Directed bench for smol_alu_arbiter with a small behavioural ALU stub on the alu_* side.
// Build with SMOL_ARB_FIXED_PRIO_EN to check the fixed-priority variant.
module tb_smol_alu_arbiter;

    localparam int PC_W   = 5;
    localparam int OP_W   = 5;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        req_valid = 2'b00;
    logic [1:0]        req_ready;
    logic [DATA_W-1:0] req0_rs1 = '0, req1_rs1 = '0;
    logic [DATA_W-1:0] req0_opnd = '0, req1_opnd = '0;
    logic [PC_W-1:0]   req0_pc = '0, req1_pc = '0;
    logic [OP_W-1:0]   req0_op = '0, req1_op = '0;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready = 2'b00;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_carry, rsp_overflow;
    logic [DATA_W-1:0] alu_rs1, alu_rs2_or_imm;
    logic [PC_W-1:0]   alu_pc;
    logic [OP_W-1:0]   alu_op_sel;
    logic [DATA_W-1:0] alu_out;
    logic              alu_carry, alu_overflow;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    smol_alu_arbiter #(.PC_W(PC_W), .OP_W(OP_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_rs1(req0_rs1), .req1_rs1(req1_rs1),
        .req0_opnd(req0_opnd), .req1_opnd(req1_opnd),
        .req0_pc(req0_pc), .req1_pc(req1_pc),
        .req0_op(req0_op), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_overflow(rsp_overflow),
        .alu_rs1(alu_rs1), .alu_rs2_or_imm(alu_rs2_or_imm),
        .alu_pc(alu_pc), .alu_op_sel(alu_op_sel),
        .alu_out(alu_out), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
        .busy(busy)
    );

    // ALU stub: 0 add, 1 sub, 2 and, 9 pc+imm, anything else 0.
    always_comb begin
        logic [DATA_W:0] sum;
        sum          = '0;
        alu_out      = '0;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        case (alu_op_sel)
            5'd0: begin
                sum          = {1'b0, alu_rs1} + {1'b0, alu_rs2_or_imm};
                alu_out      = sum[DATA_W-1:0];
                alu_carry    = sum[DATA_W];
                alu_overflow = (alu_rs1[DATA_W-1] == alu_rs2_or_imm[DATA_W-1]) &&
                               (sum[DATA_W-1] != alu_rs1[DATA_W-1]);
            end
            5'd1: alu_out = alu_rs1 - alu_rs2_or_imm;
            5'd2: alu_out = alu_rs1 & alu_rs2_or_imm;
            5'd9: alu_out = {{(DATA_W-PC_W){1'b0}}, alu_pc} + alu_rs2_or_imm;
            default: alu_out = '0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_req0(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] rs1,
                            input logic [DATA_W-1:0] opnd, input logic [PC_W-1:0] pc);
        req0_op = op; req0_rs1 = rs1; req0_opnd = opnd; req0_pc = pc;
    endtask

    task automatic set_req1(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] rs1,
                            input logic [DATA_W-1:0] opnd, input logic [PC_W-1:0] pc);
        req1_op = op; req1_rs1 = rs1; req1_opnd = opnd; req1_pc = pc;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 2'b11;
        tick();
        tick();
        n_checks++;
        if (req_ready !== 2'b00) begin
            n_fail++; $display("FAIL reset_req_ready: got %b want 00", req_ready);
        end
        n_checks++;
        if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_state: rsp_valid=%b busy=%b want 00/0", rsp_valid, busy);
        end
        n_checks++;
        if (rsp_data !== '0 || alu_rs1 !== '0 || alu_op_sel !== '0 || alu_pc !== '0) begin
            n_fail++; $display("FAIL reset_regs: rsp_data=%h alu_rs1=%h op=%0d pc=%0d want 0",
                               rsp_data, alu_rs1, alu_op_sel, alu_pc);
        end
        req_valid = 2'b00;
        rst       = 1'b0;
        tick();
    endtask

    task automatic test_single_op();
        set_req0(5'd0, 32'd5, 32'd7, 5'd0);
        req_valid = 2'b01;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin
            n_fail++; $display("FAIL single_req_ready: got %b want 01", req_ready);
        end
        tick();
        req_valid = 2'b00;
        #1;
        n_checks++;
        if (busy !== 1'b1 || rsp_valid !== 2'b00 || alu_rs1 !== 32'd5 || alu_rs2_or_imm !== 32'd7) begin
            n_fail++; $display("FAIL single_exec: busy=%b rsp_valid=%b rs1=%0d rs2=%0d want 1/00/5/7",
                               busy, rsp_valid, alu_rs1, alu_rs2_or_imm);
        end
        tick();
        n_checks++;
        if (rsp_valid !== 2'b01 || rsp_data !== 32'd12) begin
            n_fail++; $display("FAIL single_rsp: rsp_valid=%b data=%0d want 01/12", rsp_valid, rsp_data);
        end
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        n_checks++;
        if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
            n_fail++; $display("FAIL single_done: rsp_valid=%b busy=%b want 00/0", rsp_valid, busy);
        end
    endtask

    task automatic test_carry_overflow();
        set_req0(5'd0, 32'hFFFF_FFFF, 32'd1, 5'd0);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        n_checks++;
        if (rsp_data !== 32'd0 || rsp_carry !== 1'b1 || rsp_overflow !== 1'b0) begin
            n_fail++; $display("FAIL carry: data=%h c=%b v=%b want 0/1/0", rsp_data, rsp_carry, rsp_overflow);
        end
        rsp_ready = 2'b01;
        tick();
        set_req0(5'd0, 32'h7FFF_FFFF, 32'd1, 5'd0);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        n_checks++;
        if (rsp_data !== 32'h8000_0000 || rsp_carry !== 1'b0 || rsp_overflow !== 1'b1) begin
            n_fail++; $display("FAIL overflow: data=%h c=%b v=%b want 80000000/0/1", rsp_data, rsp_carry, rsp_overflow);
        end
        tick();
        rsp_ready = 2'b00;
    endtask

    task automatic test_round_robin();
        logic [1:0]        exp_ready;
        logic [DATA_W-1:0] exp_data;
        apply_reset();
        set_req0(5'd1, 32'd10, 32'd3, 5'd0);
        set_req1(5'd2, 32'hF0, 32'h3C, 5'd0);
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int i = 0; i < 4; i++) begin
`ifdef SMOL_ARB_FIXED_PRIO_EN
            exp_ready = 2'b01;
`else
            exp_ready = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
            exp_data = (exp_ready == 2'b01) ? 32'd7 : 32'h30;
            #1;
            n_checks++;
            if (req_ready !== exp_ready) begin
                n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", i, req_ready, exp_ready);
            end
            tick();
            tick();
            n_checks++;
            if (rsp_valid !== exp_ready || rsp_data !== exp_data) begin
                n_fail++; $display("FAIL rr_rsp[%0d]: rsp_valid=%b data=%h want %b/%h",
                                   i, rsp_valid, rsp_data, exp_ready, exp_data);
            end
            tick();
        end
        req_valid = 2'b00;
        rsp_ready = 2'b00;
    endtask

    task automatic test_backpressure();
        set_req0(5'd2, 32'hFF00, 32'h0FF0, 5'd0);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        req_valid = 2'b10;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) rsp_ready = 2'b10;
            tick();
            n_checks++;
            if (rsp_valid !== 2'b01 || rsp_data !== 32'h0F00 || busy !== 1'b1 || req_ready !== 2'b00) begin
                n_fail++; $display("FAIL bp_hold[%0d]: rsp_valid=%b data=%h busy=%b req_ready=%b want 01/f00/1/00",
                                   i, rsp_valid, rsp_data, busy, req_ready);
            end
        end
        req_valid = 2'b00;
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        n_checks++;
        if (busy !== 1'b0 || rsp_valid !== 2'b00) begin
            n_fail++; $display("FAIL bp_release: busy=%b rsp_valid=%b want 0/00", busy, rsp_valid);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL bp_dropped_valid: busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_in_exec();
        apply_reset();
        set_req0(5'd0, 32'd1, 32'd2, 5'd3);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        rst       = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (rsp_valid !== 2'b00 || busy !== 1'b0 || alu_rs1 !== '0 || alu_rs2_or_imm !== '0 || alu_pc !== '0) begin
            n_fail++; $display("FAIL rst_exec: rsp_valid=%b busy=%b rs1=%h rs2=%h pc=%0d want all 0",
                               rsp_valid, busy, alu_rs1, alu_rs2_or_imm, alu_pc);
        end
        tick();
        n_checks++;
        if (rsp_valid !== 2'b00) begin
            n_fail++; $display("FAIL rst_exec_no_rsp: rsp_valid=%b want 00", rsp_valid);
        end
        req_valid = 2'b11;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin
            n_fail++; $display("FAIL rst_exec_grant: got %b want 01", req_ready);
        end
        req_valid = 2'b00;
    endtask

    task automatic test_pc_and_undef_op();
        logic [4:0] ops[2];
        logic [DATA_W-1:0] exp_d[2];
        ops[0] = 5'd9;  exp_d[0] = 32'd12;
        ops[1] = 5'd25; exp_d[1] = 32'd0;
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            set_req1(ops[i], 32'hDEAD, 32'd8, 5'd4);
            req_valid = 2'b10;
            tick();
            req_valid = 2'b00;
            n_checks++;
            if (alu_pc !== 5'd4 || alu_op_sel !== ops[i] || alu_rs2_or_imm !== 32'd8) begin
                n_fail++; $display("FAIL pc_alu_regs[%0d]: pc=%0d op=%0d rs2=%0d want 4/%0d/8",
                                   i, alu_pc, alu_op_sel, alu_rs2_or_imm, ops[i]);
            end
            tick();
            n_checks++;
            if (rsp_valid !== 2'b10 || rsp_data !== exp_d[i]) begin
                n_fail++; $display("FAIL pc_rsp[%0d]: rsp_valid=%b data=%0d want 10/%0d",
                                   i, rsp_valid, rsp_data, exp_d[i]);
            end
            rsp_ready = 2'b10;
            tick();
            rsp_ready = 2'b00;
        end
    endtask

    task automatic test_lone_fairness();
        logic [1:0] exp_ready;
        apply_reset();
        set_req0(5'd0, 32'd1, 32'd1, 5'd0);
        req_valid = 2'b01;
        rsp_ready = 2'b11;
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        req_valid = 2'b11;
        #1;
`ifdef SMOL_ARB_FIXED_PRIO_EN
        exp_ready = 2'b01;
`else
        exp_ready = 2'b10;
`endif
        n_checks++;
        if (req_ready !== exp_ready) begin
            n_fail++; $display("FAIL lone_fair_grant: got %b want %b", req_ready, exp_ready);
        end
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        tick();
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_carry_overflow();
        test_round_robin();
        test_backpressure();
        test_reset_in_exec();
        test_pc_and_undef_op();
        test_lone_fairness();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
